viterbi_traceback_ctrl: RTL and testbench

Traceback sequencer for the 8-state (K=4) Viterbi decoder. It buffers one survivor-decision byte per trellis step for a frame, then walks the trellis backwards from a known termination state using the decoder's state-transition table. It emits the recovered information bits in forward order on a valid/ready stream. It sits between the add-compare-select array and the decoded-bit sink.

---
 rtl/viterbi_traceback_ctrl.sv | 176 +++++++++++++++++
 tb/tb_viterbi_traceback_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_traceback_ctrl.sv
// viterbi_traceback_ctrl
// ----------------------
// Traceback sequencer for an 8-state (K=4) Viterbi decoder. Survivor decision
// bytes (one per trellis step) are buffered during FILL. TRACE then walks the
// trellis backwards from the termination state, one step per cycle. EMIT plays
// the recovered information bits out in forward order on a valid/ready stream.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   dec_valid  decision beat valid             dec_ready  block accepts a beat
//   dec_bits   decision bit per state          dec_last   final trellis step
//   end_state  termination state (sampled on the accepted dec_last beat)
//   out_valid  decoded bit valid               out_ready  sink accepts bit
//   out_bit    decoded information bit         out_last   final bit of frame
//   busy       high in TRACE or EMIT
//   trunc      frame was closed by a full buffer without dec_last
module viterbi_traceback_ctrl #(
  parameter int MAX_LEN = 64,
  parameter int PTR_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec_valid,
  output logic       dec_ready,
  input  logic [7:0] dec_bits,
  input  logic       dec_last,
  input  logic [2:0] end_state,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_last,
  output logic       busy,
  output logic       trunc
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_LEN - 1);
  localparam logic [PTR_W:0]   ONE_LEN  = (PTR_W + 1)'(1);

  typedef enum logic [1:0] {FILL, TRACE, EMIT} state_t;

  state_t             state_reg;
  logic [PTR_W-1:0]   wptr_reg;
  logic [PTR_W-1:0]   k_reg;
  logic [PTR_W-1:0]   rptr_reg;
  logic [PTR_W:0]     len_reg;
  logic [2:0]         st_reg;
  logic               dec_ready_reg;
  logic               out_valid_reg;
  logic               out_bit_reg;
  logic               out_last_reg;
  logic               busy_reg;
  logic               trunc_reg;

  logic [7:0]         mem [MAX_LEN];
  logic [MAX_LEN-1:0] bitbuf_reg;

  logic               accept;
  logic               d_bit;
  logic               trace_bit;
  logic               out_fire;
  logic [PTR_W-1:0]   rptr_next;
  logic [PTR_W:0]     wptr_plus1;
  logic [PTR_W:0]     last_idx;

  assign accept     = dec_valid & dec_ready_reg;
  assign out_fire   = out_valid_reg & out_ready;
  assign rptr_next  = rptr_reg + PTR_W'(1);
  assign wptr_plus1 = {1'b0, wptr_reg} + ONE_LEN;
  assign last_idx   = len_reg - ONE_LEN;

  // Traceback needs the decision of the current step in the same cycle it
  // updates the state, so the survivor memory is read asynchronously.
  assign d_bit = mem[k_reg][st_reg];

  // Encoder input that drives predecessor {d, st[2:1]} into st.
  assign trace_bit = st_reg[1] ^ st_reg[0] ^ d_bit;

  assign dec_ready = dec_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_bit   = out_bit_reg;
  assign out_last  = out_last_reg;
  assign busy      = busy_reg;
  assign trunc     = trunc_reg;

  // Survivor buffer: contents are never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr_reg] <= dec_bits;
    end
  end

  // Decoded-bit buffer, filled back to front during TRACE.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_bitbuf
    always_ff @(posedge clk) begin
      if (state_reg == TRACE && k_reg == PTR_W'(gi)) begin
        bitbuf_reg[gi] <= trace_bit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= FILL;
      wptr_reg      <= '0;
      k_reg         <= '0;
      rptr_reg      <= '0;
      len_reg       <= '0;
      st_reg        <= '0;
      dec_ready_reg <= 1'b1;
      out_valid_reg <= 1'b0;
      out_bit_reg   <= 1'b0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      trunc_reg     <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          if (accept) begin
            wptr_reg <= wptr_reg + PTR_W'(1);
            // dec_last wins over a full buffer: beat MAX_LEN with dec_last
            // is a normal close.
            if (dec_last || wptr_reg == LAST_PTR) begin
              len_reg       <= wptr_plus1;
              k_reg         <= wptr_reg;
              st_reg        <= dec_last ? end_state : 3'd0;
              trunc_reg     <= ~dec_last;
              dec_ready_reg <= 1'b0;
              busy_reg      <= 1'b1;
              state_reg     <= TRACE;
            end
          end
        end

        TRACE: begin
          st_reg <= {d_bit, st_reg[2:1]};
          if (k_reg == '0) begin
            // Bit 0 is produced this cycle, so present it directly instead
            // of waiting for it to land in bitbuf.
            rptr_reg      <= '0;
            out_valid_reg <= 1'b1;
            out_bit_reg   <= trace_bit;
            out_last_reg  <= (len_reg == ONE_LEN);
            state_reg     <= EMIT;
          end else begin
            k_reg <= k_reg - PTR_W'(1);
          end
        end

        EMIT: begin
          if (out_fire) begin
            if (out_last_reg) begin
              out_valid_reg <= 1'b0;
              out_bit_reg   <= 1'b0;
              out_last_reg  <= 1'b0;
              trunc_reg     <= 1'b0;
              busy_reg      <= 1'b0;
              wptr_reg      <= '0;
              dec_ready_reg <= 1'b1;
              state_reg     <= FILL;
            end else begin
              rptr_reg     <= rptr_next;
              out_bit_reg  <= bitbuf_reg[rptr_next];
              out_last_reg <= ({1'b0, rptr_next} == last_idx);
            end
          end
        end

        default: begin
          state_reg <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_traceback_ctrl.sv
// tb_viterbi_traceback_ctrl
// -------------------------
// Scoreboard bench for viterbi_traceback_ctrl. The stimulus thread pushes the
// expected decoded bits of each frame into exp_q; a monitor thread pops and
// compares on every out_valid/out_ready handshake. Expected bits come either
// from hand-derived constants or from a reference model that walks the
// trellis by inverting the recursive encoder's next-state function.
module tb_viterbi_traceback_ctrl;

  localparam int MAX_LEN = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dec_valid = 1'b0;
  logic       dec_ready;
  logic [7:0] dec_bits = 8'h00;
  logic       dec_last = 1'b0;
  logic [2:0] end_state = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_bit;
  logic       out_last;
  logic       busy;
  logic       trunc;

  viterbi_traceback_ctrl #(.MAX_LEN(MAX_LEN), .PTR_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_bits  (dec_bits),
    .dec_last  (dec_last),
    .end_state (end_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .busy      (busy),
    .trunc     (trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit b;
    bit l;
    bit t;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fbytes[MAX_LEN];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         ready_mode = 1;
  int         pidx = 0;
  bit [3:0]   pat = 4'b1001;
  bit         lat_armed = 1'b0;
  int         accept_cyc = 0;
  int         lat_expect = 0;
  bit         post_last = 1'b0;
  bit         prev_stall = 1'b0;
  logic       prev_bit = 1'b0;
  logic       prev_last = 1'b0;
  exp_t       mon_e;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Recursive encoder: shift the state left, new LSB = u ^ s[0] ^ s[2].
  function automatic int enc_next(input int s, input int u);
    return ((s << 1) & 7) | (u ^ (s & 1) ^ ((s >> 2) & 1));
  endfunction

  // Reference traceback: follow the survivor decisions back to the
  // predecessor, then find the input that moves that predecessor forward.
  task automatic push_model(input int n, input int es, input bit t);
    bit bits[MAX_LEN];
    int s;
    int p;
    int d;
    exp_t e;
    s = es;
    for (int k = n - 1; k >= 0; k--) begin
      d = int'(fbytes[k][s]);
      p = (s >> 1) | (d << 2);
      bits[k] = 1'b0;
      for (int u = 0; u < 2; u++) begin
        if (enc_next(p, u) == s) bits[k] = u[0];
      end
      s = p;
    end
    for (int i = 0; i < n; i++) begin
      e.b = bits[i];
      e.l = (i == n - 1);
      e.t = t;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_const(input int n, input logic [63:0] bits);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.b = bits[i];
      e.l = (i == n - 1);
      e.t = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_const(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) fbytes[i] = v;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) fbytes[i] = 8'($urandom);
  endtask

  // Called and returns at #1 after a rising edge.
  task automatic send_frame(input int n, input int es, input bit use_last);
    int w;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        dec_valid = 1'b0;
        @(posedge clk); #1;
      end
      w = 0;
      while (!dec_ready && w < 500) begin
        @(posedge clk); #1;
        w++;
      end
      if (w >= 500) chk("dec_ready_timeout", 32'(w), 0);
      dec_valid = 1'b1;
      dec_bits  = fbytes[i];
      dec_last  = use_last && (i == n - 1);
      end_state = dec_last ? 3'(es) : 3'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    dec_valid  = 1'b0;
    dec_last   = 1'b0;
    dec_bits   = 8'($urandom);
    accept_cyc = cyc;
    lat_expect = n;
    lat_armed  = 1'b1;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || !dec_ready || post_last || lat_armed) && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("drain_timeout", 32'(c < 3000), 1);
    if (c >= 3000) begin
      exp_q.delete();
      lat_armed = 1'b0;
      post_last = 1'b0;
    end
  endtask

  // out_ready driver: random, always high, or the 1,0,0,1 pattern per EMIT cycle.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = ($urandom_range(0, 3) != 0);
        1: out_ready = 1'b1;
        default: begin
          if (out_valid) begin
            out_ready = pat[pidx % 4];
            pidx++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (lat_armed) begin
        if (out_valid) begin
          // First bit appears len edges after the closing beat's edge.
          chk("first_bit_latency", 32'(cyc - accept_cyc), 32'(lat_expect));
          lat_armed = 1'b0;
        end else begin
          chk("trace_busy", 32'(busy), 1);
          chk("trace_dec_ready", 32'(dec_ready), 0);
        end
      end
      if (post_last) begin
        chk("after_last_dec_ready", 32'(dec_ready), 1);
        chk("after_last_busy", 32'(busy), 0);
        chk("after_last_trunc", 32'(trunc), 0);
        chk("after_last_out_valid", 32'(out_valid), 0);
        post_last = 1'b0;
      end
      if (out_valid) begin
        chk("emit_dec_ready", 32'(dec_ready), 0);
        chk("emit_busy", 32'(busy), 1);
        if (prev_stall) begin
          chk("stall_out_bit", 32'(out_bit), 32'(prev_bit));
          chk("stall_out_last", 32'(out_last), 32'(prev_last));
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'(out_valid), 0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("out_bit", 32'(out_bit), 32'(mon_e.b));
            chk("out_last", 32'(out_last), 32'(mon_e.l));
            chk("trunc", 32'(trunc), 32'(mon_e.t));
          end
          if (out_last) post_last = 1'b1;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_bit   = out_bit;
          prev_last  = out_last;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int es;
    bit ul;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("reset_dec_ready", 32'(dec_ready), 1);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_bit", 32'(out_bit), 0);
    chk("reset_out_last", 32'(out_last), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_trunc", 32'(trunc), 0);
    @(posedge clk); #1;

    // len=3, all-zero decisions from state 4: 4<-2<-1<-0 gives 1,1,0.
    ready_mode = 1;
    fill_const(3, 8'h00);
    push_const(3, 64'b011);
    send_frame(3, 4, 1'b1);
    drain();

    // len=2, all-one decisions from state 0: 0<-4<-6 gives 1,1.
    fill_const(2, 8'hFF);
    push_const(2, 64'b11);
    send_frame(2, 0, 1'b1);
    drain();

    // len=1: single bit 0 with out_last.
    fill_const(1, 8'h00);
    push_const(1, 64'b0);
    send_frame(1, 0, 1'b1);
    drain();

    // Full buffer without dec_last: truncated close from state 0.
    ready_mode = 0;
    fill_random(MAX_LEN);
    push_model(MAX_LEN, 0, 1'b1);
    send_frame(MAX_LEN, 0, 1'b0);
    drain();

    // Sink stalls with the 1,0,0,1 ready pattern.
    ready_mode = 2;
    pidx = 0;
    fill_const(3, 8'h00);
    push_const(3, 64'b011);
    send_frame(3, 4, 1'b1);
    drain();

    // dec_last on beat MAX_LEN is a normal close.
    ready_mode = 1;
    es = $urandom_range(0, 7);
    fill_random(MAX_LEN);
    push_model(MAX_LEN, es, 1'b0);
    send_frame(MAX_LEN, es, 1'b1);
    drain();

    // Reset in the middle of TRACE of a truncated frame aborts it.
    fill_random(MAX_LEN);
    push_model(MAX_LEN, 0, 1'b1);
    send_frame(MAX_LEN, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("pre_reset_trunc", 32'(trunc), 1);
    chk("pre_reset_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 0);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_trunc", 32'(trunc), 0);
    exp_q.delete();
    lat_armed  = 1'b0;
    post_last  = 1'b0;
    prev_stall = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_reset_dec_ready", 32'(dec_ready), 1);
    chk("post_reset_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;

    fill_const(3, 8'h00);
    push_const(3, 64'b011);
    send_frame(3, 4, 1'b1);
    drain();

    // Randomized frames against the reference model.
    for (int f = 0; f < 20; f++) begin
      ready_mode = $urandom_range(0, 1);
      n  = $urandom_range(1, MAX_LEN);
      ul = (n < MAX_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
      es = ul ? $urandom_range(0, 7) : 0;
      fill_random(n);
      push_model(n, es, ~ul);
      send_frame(n, es, ul);
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
